// File: rtl/uart_pkg.sv
// Shared uart types: byte alias and the tx-fifo launch FSM encoding.
package uart_pkg;
  typedef logic [7:0] uart_byte_t;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT} tx_fifo_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the uart transmitter: absorbs host bursts and launches
// one byte per uart frame with a single-cycle wr_en strobe.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              push,
  input  uart_byte_t        push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              idle,
  output uart_byte_t        uart_din,
  output logic              uart_wr_en,
  input  logic              uart_tx_busy
);

  uart_byte_t        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  tx_fifo_state_t    state, state_nxt;
  logic              pop, push_ok, drop, wr_en_nxt;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign idle    = empty && (state == S_IDLE) && !uart_tx_busy;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_en_nxt = 1'b0;
    case (state)
      S_IDLE: if (!empty && !uart_tx_busy) begin
        pop       = 1'b1;
        wr_en_nxt = 1'b1;
        state_nxt = S_LAUNCH;
      end
      S_LAUNCH: state_nxt = S_SETTLE;
      // uart raises busy a cycle late, so busy is not trusted here
      S_SETTLE: state_nxt = S_WAIT;
      S_WAIT:   if (!uart_tx_busy) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_50m) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      uart_wr_en <= 1'b0;
      uart_din   <= '0;
    end else begin
      uart_wr_en <= wr_en_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        uart_din <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: queue-based reference model, scoreboard
// of launched bytes, and a small busy-generating uart transmitter model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 0;
  logic       rst, push, ovf_clr;
  logic [7:0] push_data;
  logic       full, empty, overflow, idle, uart_wr_en;
  logic [4:0] count;
  logic [7:0] uart_din;
  logic       uart_tx_busy;

  logic busy_hold;
  int   busy_len, busy_cnt;

  int errors = 0, checks = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf, m_rel, m_wr, launch, dropped;
  logic [7:0] m_din, b;
  int         m_since;
  bit         rst_seen;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_50m(clk), .rst(rst), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .idle(idle), .uart_din(uart_din),
    .uart_wr_en(uart_wr_en), .uart_tx_busy(uart_tx_busy)
  );

  always #5 clk = ~clk;

  // uart model: busy from the cycle after wr_en for busy_len cycles
  assign uart_tx_busy = busy_hold || (busy_cnt != 0);
  initial busy_cnt = 0;
  always @(negedge clk) begin
    if (uart_wr_en === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0)   busy_cnt = busy_cnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a byte queue; a launch takes the head whenever the line has been
  // released (>=3 cycles after the last launch with the uart seen not busy).
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_rel = 1; m_since = 0; m_wr = 0; m_din = 8'h00;
      rst_seen = 1;
    end else begin
      launch = m_rel && (mq.size() > 0) && !uart_tx_busy;
      m_wr = launch;
      if (launch) begin
        b = mq.pop_front();
        m_din = b;
        exp_q.push_back(b);
      end
      dropped = 0;
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(push_data);
        else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (launch) begin
        m_rel = 0; m_since = 0;
      end else begin
        if (m_since < 15) m_since++;
        if (!m_rel && m_since >= 3 && !uart_tx_busy) m_rel = 1;
      end
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on each launch
  int cyc_n = 0, last_wr = -100;
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc_n++;
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("idle", 32'(idle), 32'(mq.size() == 0 && m_rel && !uart_tx_busy));
      chk("wr_en", 32'(uart_wr_en), 32'(m_wr));
      chk("din", 32'(uart_din), 32'(m_din));
      if (uart_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL sb_extra: got launch of %0h expected none", uart_din);
        end else chk("sb_byte", 32'(uart_din), 32'(exp_q.pop_front()));
        if (!rst_seen) chk("wr_spacing_ok", 32'(cyc_n - last_wr >= 3), 32'd1);
        last_wr = cyc_n;
        rst_seen = 0;
      end
    end
  end

  task automatic cyc(input logic p, input logic [7:0] d, input logic oc);
    @(negedge clk);
    push = p; push_data = d; ovf_clr = oc;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (!(mq.size() == 0 && m_rel && !uart_tx_busy && exp_q.size() == 0) && n < lim) begin
      @(negedge clk); n++;
    end
    chk("drain_in_time", 32'(n < lim), 32'd1);
  endtask

  initial begin
    bit   found;
    int   thr;
    rst = 1; push = 1; push_data = 8'h5A; ovf_clr = 0;
    busy_hold = 0; busy_len = 3;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_wr_en", 32'(uart_wr_en), 32'd0);
    chk("rst_din", 32'(uart_din), 32'h00);
    rst = 0; push = 0;

    // single byte
    cyc(1, 8'hA5, 0);
    cyc(0, 8'h00, 0);
    found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(posedge clk); #1;
      if (uart_wr_en) begin
        found = 1;
        chk("single_din", 32'(uart_din), 32'hA5);
      end
    end
    chk("single_launch_seen", 32'(found), 32'd1);
    repeat (8) cyc(0, 8'h00, 0);
    chk("single_count", 32'(count), 32'd0);

    // burst to full, then overflow
    busy_len = 20; busy_hold = 1;
    for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0);
    cyc(0, 8'h00, 0);
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_count", 32'(count), 32'd16);
    cyc(1, 8'hFF, 0);
    cyc(0, 8'h00, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // push into full FIFO on the launch cycle
    busy_hold = 0; push = 1; push_data = 8'h77;
    cyc(0, 8'h00, 0);
    chk("simul_count", 32'(count), 32'd16);
    chk("simul_ovf", 32'(overflow), 32'd0);
    wait_drain(1000);

    // reset while the FSM is waiting on the uart
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(0, 8'h00, 0);
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstwait_wr_en", 32'(uart_wr_en), 32'd0);
    chk("rstwait_empty", 32'(empty), 32'd1);
    wait_drain(200);

    // random traffic
    thr = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) begin
        thr = $urandom_range(1, 7);
        busy_len = $urandom_range(1, 6);
      end
      @(negedge clk);
      push      = ($urandom_range(0, 7) < thr);
      push_data = 8'($urandom);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) busy_hold = ~busy_hold;
    end
    @(negedge clk);
    push = 0; ovf_clr = 0; rst = 0; busy_hold = 0;
    wait_drain(2000);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
